// File: rtl/mem_port_arbiter.sv
// Two-port access controller for the 5-row, 16-bit row memory: serialises port 0 / port 1
// requests, rejects unpopulated rows, returns read data with a one-cycle ack. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter #(
    parameter int DEPTH = 5,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic          err0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata1,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic          own;
    logic          we_q;
    logic          gnt1;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_ok;

`ifdef MEM_ARB_RR_EN
    logic          ptr;
`endif

    always_comb begin
        gnt1 = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (req0 && req1) begin
            gnt1 = ptr;
        end else begin
            gnt1 = req1;
        end
`else
        gnt1 = req1 && !req0;
`endif
        sel_we    = gnt1 ? we1    : we0;
        sel_addr  = gnt1 ? addr1  : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
        // Extra bit keeps the bound check correct when DEPTH == 2**AW.
        sel_ok    = {1'b0, sel_addr} < (AW+1)'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            own      <= 1'b0;
            we_q     <= 1'b0;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            busy     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        own  <= gnt1;
                        we_q <= sel_we;
                        busy <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        ptr  <= ~ptr;
`endif
                        if (sel_ok) begin
                            state    <= ACC;
                            mem_cs   <= 1'b1;
                            mem_we   <= sel_we;
                            mem_addr <= sel_addr;
                            mem_din  <= sel_wdata;
                        end else begin
                            // Out-of-range: skip the memory cycle, answer straight away.
                            state <= RESP;
                            if (gnt1) begin
                                ack1 <= 1'b1;
                                err1 <= 1'b1;
                            end else begin
                                ack0 <= 1'b1;
                                err0 <= 1'b1;
                            end
                        end
                    end
                end
                ACC: begin
                    state  <= RESP;
                    mem_cs <= 1'b0;
                    mem_we <= 1'b0;
                    if (own) begin
                        ack1 <= 1'b1;
                        if (!we_q) begin
                            rdata1 <= mem_dout;
                        end
                    end else begin
                        ack0 <= 1'b1;
                        if (!we_q) begin
                            rdata0 <= mem_dout;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
